// File: rtl/rfphoenix_dcache_wrbuf.sv
// Store write buffer between the dcache write-enable generator and the data RAM.
// Merges stores to pending lines and drains one line per cycle when the read port is idle.
module rfphoenix_dcache_wrbuf #(
    parameter int DEPTH = 4,
    parameter int AWID  = 32,
    parameter int LOBIT = 6,
    parameter int WAYS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr,
    input  logic [AWID-1:0]              wr_adr,
    input  logic [$clog2(WAYS)-1:0]      wr_way,
    input  logic [(8<<LOBIT)-1:0]        wr_dat,
    input  logic [(1<<LOBIT)-1:0]        wr_sel,
    input  logic                         rd_busy,
    input  logic [AWID-1:0]              rd_adr,
    output logic                         ram_we,
    output logic [AWID-LOBIT-1:0]        ram_adr,
    output logic [$clog2(WAYS)-1:0]      ram_way,
    output logic [(8<<LOBIT)-1:0]        ram_dat,
    output logic [(1<<LOBIT)-1:0]        ram_sel,
    output logic                         rd_hazard,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf
);
    localparam int WW = $clog2(WAYS);
    localparam int LW = AWID - LOBIT;
    localparam int SW = 1 << LOBIT;
    localparam int DW = 8 * SW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [LW-1:0]    line_q [DEPTH];
    logic [LW-1:0]    line_d [DEPTH];
    logic [WW-1:0]    way_q  [DEPTH];
    logic [WW-1:0]    way_d  [DEPTH];
    logic [DW-1:0]    dat_q  [DEPTH];
    logic [DW-1:0]    dat_d  [DEPTH];
    logic [SW-1:0]    sel_q  [DEPTH];
    logic [SW-1:0]    sel_d  [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ram_we_q, ram_we_d;
    logic [LW-1:0] ram_adr_q, ram_adr_d;
    logic [WW-1:0] ram_way_q, ram_way_d;
    logic [DW-1:0] ram_dat_q, ram_dat_d;
    logic [SW-1:0] ram_sel_q, ram_sel_d;

    logic [LW-1:0]    wr_line, rd_line;
    logic [DEPTH-1:0] hit, haz;
    logic             pop, merge, alloc, drop;
    logic             unused_lo;

    assign wr_line   = wr_adr[AWID-1:LOBIT];
    assign rd_line   = rd_adr[AWID-1:LOBIT];
    assign unused_lo = ^{wr_adr[LOBIT-1:0], rd_adr[LOBIT-1:0]};

    // The head entry leaving this edge is not a merge target: the store must land in a fresh entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign hit[gi] = valid_q[gi] && (line_q[gi] == wr_line) && (way_q[gi] == wr_way)
                         && !(pop && (head_q == PW'(gi)));
        assign haz[gi] = valid_q[gi] && (line_q[gi] == rd_line);
    end

    assign pop   = (count_q != '0) && !rd_busy;
    assign merge = wr && (|hit);
    assign alloc = wr && !merge && ((count_q != CW'(DEPTH)) || pop);
    assign drop  = wr && !merge && (count_q == CW'(DEPTH)) && !pop;

    always_comb begin
        valid_d   = valid_q;
        line_d    = line_q;
        way_d     = way_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        head_d    = head_q;
        tail_d    = tail_q;
        ovf_d     = ovf_q | drop;
        ram_we_d  = 1'b0;
        ram_adr_d = ram_adr_q;
        ram_way_d = ram_way_q;
        ram_dat_d = ram_dat_q;
        ram_sel_d = ram_sel_q;

        if (pop) begin
            ram_we_d        = 1'b1;
            ram_adr_d       = line_q[head_q];
            ram_way_d       = way_q[head_q];
            ram_dat_d       = dat_q[head_q];
            ram_sel_d       = sel_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        // Allocation after pop: when full, tail equals the head slot just vacated.
        if (merge) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wr_sel[b]) dat_d[i][8*b +: 8] = wr_dat[8*b +: 8];
                    end
                    sel_d[i] = sel_q[i] | wr_sel;
                end
            end
        end else if (alloc) begin
            valid_d[tail_q] = 1'b1;
            line_d[tail_q]  = wr_line;
            way_d[tail_q]   = wr_way;
            dat_d[tail_q]   = wr_dat;
            sel_d[tail_q]   = wr_sel;
            tail_d          = tail_q + 1'b1;
        end

        count_d = count_q + CW'(alloc) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_adr_q <= '0;
            ram_way_q <= '0;
            ram_dat_q <= '0;
            ram_sel_q <= '0;
        end else begin
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ram_we_q  <= ram_we_d;
            ram_adr_q <= ram_adr_d;
            ram_way_q <= ram_way_d;
            ram_dat_q <= ram_dat_d;
            ram_sel_q <= ram_sel_d;
        end
    end

    // Payload is only meaningful under a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
        way_q  <= way_d;
        dat_q  <= dat_d;
        sel_q  <= sel_d;
    end

    assign ram_we    = ram_we_q;
    assign ram_adr   = ram_adr_q;
    assign ram_way   = ram_way_q;
    assign ram_dat   = ram_dat_q;
    assign ram_sel   = ram_sel_q;
    assign rd_hazard = |haz;
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rfphoenix_dcache_wrbuf.sv
// Randomized bench for the dcache store write buffer against a queue-based reference model.
module tb_rfphoenix_dcache_wrbuf;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr;
    logic [31:0]  wr_adr;
    logic [1:0]   wr_way;
    logic [511:0] wr_dat;
    logic [63:0]  wr_sel;
    logic         rd_busy;
    logic [31:0]  rd_adr;
    logic         ram_we;
    logic [25:0]  ram_adr;
    logic [1:0]   ram_way;
    logic [511:0] ram_dat;
    logic [63:0]  ram_sel;
    logic         rd_hazard;
    logic [2:0]   count;
    logic         full, empty, ovf;

    rfphoenix_dcache_wrbuf dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wr_adr(wr_adr), .wr_way(wr_way),
        .wr_dat(wr_dat), .wr_sel(wr_sel), .rd_busy(rd_busy), .rd_adr(rd_adr),
        .ram_we(ram_we), .ram_adr(ram_adr), .ram_way(ram_way), .ram_dat(ram_dat),
        .ram_sel(ram_sel), .rd_hazard(rd_hazard), .count(count), .full(full),
        .empty(empty), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0]  line;
        logic [1:0]   way;
        logic [511:0] dat;
        logic [63:0]  sel;
    } ent_t;

    ent_t         q[$];
    logic         m_we, m_ovf;
    logic [25:0]  m_adr;
    logic [1:0]   m_way;
    logic [511:0] m_dat;
    logic [63:0]  m_sel;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rline();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        m_we = 0; m_ovf = 0; m_adr = '0; m_way = '0; m_dat = '0; m_sel = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".count"}, 512'(count), 512'(q.size()));
        chk({tag, ".full"}, 512'(full), 512'(q.size() == 4));
        chk({tag, ".empty"}, 512'(empty), 512'(q.size() == 0));
        chk({tag, ".ovf"}, 512'(ovf), 512'(m_ovf));
        chk({tag, ".ram_we"}, 512'(ram_we), 512'(m_we));
        chk({tag, ".ram_adr"}, 512'(ram_adr), 512'(m_adr));
        chk({tag, ".ram_way"}, 512'(ram_way), 512'(m_way));
        chk({tag, ".ram_dat"}, ram_dat, m_dat);
        chk({tag, ".ram_sel"}, 512'(ram_sel), 512'(m_sel));
    endtask

    // One clock: drive at negedge, check hazard, update model at posedge, check state next negedge.
    task automatic step(input string tag, input logic w, input logic [31:0] a, input logic [1:0] wy,
                        input logic [511:0] d, input logic [63:0] s, input logic busy,
                        input logic [31:0] ra);
        logic exp_haz;
        logic found;
        ent_t e;
        wr = w; wr_adr = a; wr_way = wy; wr_dat = d; wr_sel = s; rd_busy = busy; rd_adr = ra;
        #1;
        exp_haz = 0;
        foreach (q[k]) if (q[k].line == ra[31:6]) exp_haz = 1;
        chk({tag, ".rd_hazard"}, 512'(rd_hazard), 512'(exp_haz));
        @(posedge clk);
        if (q.size() != 0 && !busy) begin
            e = q.pop_front();
            m_we = 1; m_adr = e.line; m_way = e.way; m_dat = e.dat; m_sel = e.sel;
        end else begin
            m_we = 0;
        end
        if (w) begin
            found = 0;
            foreach (q[k]) begin
                if (q[k].line == a[31:6] && q[k].way == wy) begin
                    e = q[k];
                    for (int b = 0; b < 64; b++) if (s[b]) e.dat[8*b +: 8] = d[8*b +: 8];
                    e.sel = e.sel | s;
                    q[k] = e;
                    found = 1;
                end
            end
            if (!found) begin
                if (q.size() < 4) begin
                    e.line = a[31:6]; e.way = wy; e.dat = d; e.sel = s;
                    q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(negedge clk);
        check_regs(tag);
        $display("step %s wr=%0b adr=%h way=%0d busy=%0b -> count=%0d ram_we=%0b ram_adr=%h",
                 tag, w, a, wy, busy, count, ram_we, ram_adr);
    endtask

    task automatic idle(input string tag, input logic busy);
        step(tag, 1'b0, 32'h0, 2'd0, 512'h0, 64'h0, busy, 32'hFFFF_FFC0);
    endtask

    task automatic do_reset(input string tag);
        wr = 0; rd_busy = 0;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_regs(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [511:0] d;
        logic [63:0]  s;
        logic [31:0]  a, ra;
        logic         busy;
        rst_n = 1'b0; wr = 0; wr_adr = '0; wr_way = '0; wr_dat = '0; wr_sel = '0;
        rd_busy = 0; rd_adr = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        do_reset("reset0");

        // Single store latency
        step("t1_wr", 1, 32'h1040, 2'd2, 512'hDEADBEEF, 64'hF, 0, 32'h0);
        idle("t1_pop", 0);
        chk("t1_we", 512'(ram_we), 512'(1));
        chk("t1_adr", 512'(ram_adr), 512'h41);
        chk("t1_way", 512'(ram_way), 512'd2);
        chk("t1_sel", 512'(ram_sel), 512'hF);
        idle("t1_after", 0);
        chk("t1_empty", 512'(empty), 512'(1));

        // Merge of two byte stores to one line
        step("t2_a", 1, 32'h2000, 2'd0, 512'hAA, 64'h1, 1, 32'h0);
        step("t2_b", 1, 32'h2001, 2'd0, 512'hBB00, 64'h2, 1, 32'h0);
        chk("t2_count", 512'(count), 512'd1);
        idle("t2_drain", 0);
        chk("t2_sel", 512'(ram_sel), 512'h3);
        chk("t2_bytes", 512'(ram_dat[15:0]), 512'hBBAA);

        // Overflow when full and blocked
        for (int i = 0; i < 5; i++)
            step("t3_fill", 1, 32'h3000 + 32'(i * 64), 2'd0, rline(), 64'hFF, 1, 32'h0);
        chk("t3_ovf", 512'(ovf), 512'(1));
        chk("t3_count", 512'(count), 512'd4);
        idle("t3_drain0", 0);
        chk("t3_first", 512'(ram_adr), 512'hC0);
        for (int i = 0; i < 4; i++) idle("t3_drain", 0);
        chk("t3_ovf_hold", 512'(ovf), 512'(1));

        // Allocate into a full buffer on the same edge as a pop
        do_reset("reset1");
        for (int i = 0; i < 4; i++)
            step("t4_fill", 1, 32'h4000 + 32'(i * 64), 2'd1, rline(), 64'hF0, 1, 32'h0);
        step("t4_wrap", 1, 32'h5000, 2'd1, rline(), 64'h0F, 0, 32'h0);
        chk("t4_count", 512'(count), 512'd4);
        chk("t4_no_ovf", 512'(ovf), 512'(0));
        for (int i = 0; i < 5; i++) idle("t4_drain", 0);

        // Load hazard detection
        step("t5_wr", 1, 32'h2000, 2'd0, rline(), 64'h1, 1, 32'h0);
        rd_adr = 32'h2010; #1;
        chk("t5_haz_hit", 512'(rd_hazard), 512'(1));
        rd_adr = 32'h3000; #1;
        chk("t5_haz_miss", 512'(rd_hazard), 512'(0));
        @(negedge clk);
        idle("t5_drain", 0);
        rd_adr = 32'h2010; #1;
        chk("t5_haz_clear", 512'(rd_hazard), 512'(0));
        @(negedge clk);

        // Reset during drain
        for (int i = 0; i < 3; i++)
            step("t6_fill", 1, 32'h6000 + 32'(i * 64), 2'd3, rline(), 64'h3, 1, 32'h0);
        idle("t6_pop", 0);
        chk("t6_we_before", 512'(ram_we), 512'(1));
        do_reset("t6_reset");
        for (int i = 0; i < 3; i++) idle("t6_after", 0);

        // Randomized traffic over a small set of lines to exercise merges
        for (int i = 0; i < 600; i++) begin
            a  = {26'h100 + 26'($urandom_range(0, 5)), 6'($urandom_range(0, 63))};
            ra = {26'h100 + 26'($urandom_range(0, 7)), 6'($urandom_range(0, 63))};
            d  = rline();
            s  = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
            busy = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step("rnd", ($urandom_range(0, 2) != 0), a, 2'($urandom_range(0, 1)), d, s, busy, ra);
            if (i == 300) do_reset("rnd_reset");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
